bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder_if.sv | 51 +++++
 rtl/bus_mem_responder.sv | 137 +++++++++++++
 tb/tb_bus_mem_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_mem_responder_if.sv
// ---------------------------------------------------------------------------
// bus_mem_responder_if
// Purpose : bundles the initiator/responder handshake of the simple memory
//           bus into a single connection object.
// Signals :
//   BUS_start_transaction  initiator request strobe
//   BUS_mode               0 = read, 1 = write (qualified by start)
//   BUS_addr               byte address (qualified by start)
//   BUS_wdata              write data (qualified by start)
//   BUS_rdata              read data, valid with BUS_rdata_valid, held after
//   BUS_rdata_valid        one-cycle read-complete pulse
//   BUS_write_done         one-cycle write-complete pulse
//   BUS_busy               high while a transaction is in flight
//   BUS_err                one-cycle illegal-access flag, with the completion
// Modports: master (initiator side), slave (responder side)
// ---------------------------------------------------------------------------
interface bus_mem_responder_if;
  logic        BUS_start_transaction;
  logic        BUS_mode;
  logic [31:0] BUS_addr;
  logic [31:0] BUS_wdata;
  logic [31:0] BUS_rdata;
  logic        BUS_rdata_valid;
  logic        BUS_write_done;
  logic        BUS_busy;
  logic        BUS_err;

  modport master (
    output BUS_start_transaction,
    output BUS_mode,
    output BUS_addr,
    output BUS_wdata,
    input  BUS_rdata,
    input  BUS_rdata_valid,
    input  BUS_write_done,
    input  BUS_busy,
    input  BUS_err
  );

  modport slave (
    input  BUS_start_transaction,
    input  BUS_mode,
    input  BUS_addr,
    input  BUS_wdata,
    output BUS_rdata,
    output BUS_rdata_valid,
    output BUS_write_done,
    output BUS_busy,
    output BUS_err
  );
endinterface

// File: rtl/bus_mem_responder.sv
// ---------------------------------------------------------------------------
// bus_mem_responder
// Purpose : single-ported word memory answering one bus transaction at a time
//           with a programmable number of wait states.  Misaligned or
//           out-of-range accesses complete normally but flag BUS_err; they
//           never touch memory and reads return zero.
// Parameters:
//   ADDR_W       log2 of the word count (2^ADDR_W 32-bit words), 1..29
//   WAIT_CYCLES  extra wait states per transaction, 0..15
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (memory contents are not reset)
//   bus    responder side of bus_mem_responder_if
// Timing : a start sampled in IDLE at edge N keeps BUS_busy high for
//          WAIT_CYCLES+2 cycles and produces the completion pulse in the
//          cycle after edge N+WAIT_CYCLES+2.
// ---------------------------------------------------------------------------
module bus_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  bus_mem_responder_if.slave bus
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic        r_mode;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rd_word;
  logic [31:0] r_rdata;
  logic        r_rdata_valid;
  logic        r_write_done;
  logic        r_busy;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic              w_illegal;
  logic [ADDR_W-1:0] w_idx;
  logic              w_mem_we;
  logic              w_mem_re;

  // Legality and word index are derived from the captured address so that
  // bus activity during a transaction cannot disturb it.
  assign w_illegal = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_W+2] != '0);
  assign w_idx     = r_addr[ADDR_W+1:2];
  assign w_mem_we  = (r_state == S_ACCESS) &&  r_mode && !w_illegal;
  assign w_mem_re  = (r_state == S_ACCESS) && !r_mode;

  // Memory array: no reset so it maps onto block RAM.  The access happens in
  // the single ACCESS cycle; an illegal write is suppressed by w_mem_we.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_wdata;
    end
    if (w_mem_re) begin
      r_rd_word <= r_mem[w_idx];
    end
  end

  // Transaction FSM with registered outputs.  The completion pulses are
  // produced while leaving RESP, so they appear in the cycle after RESP and
  // last exactly one cycle because they default low every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 4'd0;
      r_mode        <= 1'b0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_rdata       <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_write_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_write_done  <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.BUS_start_transaction) begin
            r_mode     <= bus.BUS_mode;
            r_addr     <= bus.BUS_addr;
            r_wdata    <= bus.BUS_wdata;
            r_wait_cnt <= WAIT_LOAD;
            r_busy     <= 1'b1;
            r_state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (r_wait_cnt == 4'd1) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (r_mode) begin
            r_write_done <= 1'b1;
          end else begin
            r_rdata_valid <= 1'b1;
            r_rdata       <= w_illegal ? 32'd0 : r_rd_word;
          end
          r_err   <= w_illegal;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.BUS_rdata       = r_rdata;
  assign bus.BUS_rdata_valid = r_rdata_valid;
  assign bus.BUS_write_done  = r_write_done;
  assign bus.BUS_busy        = r_busy;
  assign bus.BUS_err         = r_err;

endmodule

// File: tb/tb_bus_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_mem_responder
// Purpose : self-checking bench for bus_mem_responder.  One instance uses two
//           wait states and is compared against a word-array reference model;
//           a second instance with zero wait states covers back-to-back
//           write/read timing.
// ---------------------------------------------------------------------------
module tb_bus_mem_responder;

  localparam int ADDR_W = 8;
  localparam int WAIT0  = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bus_mem_responder_if busA();
  bus_mem_responder_if busB();

  bus_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT0)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  bus_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] refMem [DEPTH];
  logic [31:0] refRdataA = 32'd0;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // An access is legal when word aligned and inside the memory's byte range.
  function automatic bit isLegal(input logic [31:0] addr);
    return (addr % 4 == 0) && (addr < 32'(4 * DEPTH));
  endfunction

  // One transaction on instance A; optionally pulses a second start at
  // sample index dupAt (which must be ignored while busy).
  task automatic applyStimulus(input logic mode, input logic [31:0] addr,
                               input logic [31:0] wdata, input int dupAt);
    bit          legal;
    logic [31:0] expRd = 32'd0;
    int          pulseAt = -1;
    int          pulses = 0;
    int          busyCnt = 0;
    logic        gotDone = 1'b0;
    logic        gotValid = 1'b0;
    logic        gotErr = 1'b0;
    logic [31:0] gotRdata = 32'd0;
    legal = isLegal(addr);
    if (mode) begin
      if (legal) refMem[addr >> 2] = wdata;
    end else begin
      expRd     = legal ? refMem[addr >> 2] : 32'd0;
      refRdataA = expRd;
    end
    @(negedge clk);
    busA.BUS_start_transaction = 1'b1;
    busA.BUS_mode  = mode;
    busA.BUS_addr  = addr;
    busA.BUS_wdata = wdata;
    for (int j = 0; j <= WAIT0 + 6; j++) begin
      @(negedge clk);
      busyCnt += int'(busA.BUS_busy);
      if (busA.BUS_write_done || busA.BUS_rdata_valid) begin
        pulses++;
        if (pulseAt < 0) begin
          pulseAt  = j;
          gotDone  = busA.BUS_write_done;
          gotValid = busA.BUS_rdata_valid;
          gotErr   = busA.BUS_err;
          gotRdata = busA.BUS_rdata;
        end
      end
      busA.BUS_start_transaction = (j == dupAt);
      busA.BUS_mode  = 1'($urandom_range(0, 1));
      busA.BUS_addr  = $urandom;
      busA.BUS_wdata = $urandom;
    end
    busA.BUS_start_transaction = 1'b0;
    checkOutput("latency", 32'(pulseAt), 32'(WAIT0 + 2));
    checkOutput("pulseCount", 32'(pulses), 32'd1);
    checkOutput("busyCycles", 32'(busyCnt), 32'(WAIT0 + 2));
    checkOutput("doneFlag", 32'(gotDone), 32'(mode));
    checkOutput("validFlag", 32'(gotValid), 32'(!mode));
    checkOutput("errFlag", 32'(gotErr), 32'(!legal));
    if (!mode) checkOutput("readData", gotRdata, expRd);
    checkOutput("rdataHold", busA.BUS_rdata, refRdataA);
  endtask

  // Starts a write on instance A and asserts reset during its wait states;
  // nothing may complete and memory must keep its old contents.
  task automatic applyResetMid(input logic [31:0] addr, input logic [31:0] wdata);
    int pulses = 0;
    @(negedge clk);
    busA.BUS_start_transaction = 1'b1;
    busA.BUS_mode  = 1'b1;
    busA.BUS_addr  = addr;
    busA.BUS_wdata = wdata;
    @(negedge clk);
    busA.BUS_start_transaction = 1'b0;
    checkOutput("busyBeforeReset", 32'(busA.BUS_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("resetBusy", 32'(busA.BUS_busy), 32'd0);
    checkOutput("resetValid", 32'(busA.BUS_rdata_valid), 32'd0);
    checkOutput("resetDone", 32'(busA.BUS_write_done), 32'd0);
    checkOutput("resetErr", 32'(busA.BUS_err), 32'd0);
    checkOutput("resetRdata", busA.BUS_rdata, 32'd0);
    refRdataA = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (busA.BUS_write_done || busA.BUS_rdata_valid || busA.BUS_err) pulses++;
    end
    checkOutput("abortNoPulse", 32'(pulses), 32'd0);
  endtask

  // Zero-wait instance: write then read the same word, the read issued in
  // the very cycle the write completes.
  task automatic runFastPair(input logic [31:0] addr, input logic [31:0] wdata);
    int          wAt = -1;
    int          rAt = -1;
    logic [31:0] rdGot = 32'd0;
    logic        errSeen = 1'b0;
    @(negedge clk);
    busB.BUS_start_transaction = 1'b1;
    busB.BUS_mode  = 1'b1;
    busB.BUS_addr  = addr;
    busB.BUS_wdata = wdata;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      busB.BUS_start_transaction = 1'b0;
      errSeen = errSeen | busB.BUS_err;
      if (busB.BUS_rdata_valid && rAt < 0) begin
        rAt   = j;
        rdGot = busB.BUS_rdata;
      end
      if (busB.BUS_write_done && wAt < 0) begin
        wAt = j;
        busB.BUS_start_transaction = 1'b1;
        busB.BUS_mode  = 1'b0;
        busB.BUS_wdata = $urandom;
      end
    end
    busB.BUS_start_transaction = 1'b0;
    checkOutput("fastWriteLatency", 32'(wAt), 32'd2);
    checkOutput("fastReadLatency", 32'(rAt - wAt - 1), 32'd2);
    checkOutput("fastReadData", rdGot, wdata);
    checkOutput("fastErr", 32'(errSeen), 32'd0);
    checkOutput("fastHold", busB.BUS_rdata, wdata);
  endtask

  // Main sequence: reset, fill memory, directed cases, then random traffic.
  initial begin
    logic [31:0] addr;
    int          sel;
    int          dup;
    busA.BUS_start_transaction = 1'b0;
    busA.BUS_mode  = 1'b0;
    busA.BUS_addr  = 32'd0;
    busA.BUS_wdata = 32'd0;
    busB.BUS_start_transaction = 1'b0;
    busB.BUS_mode  = 1'b0;
    busB.BUS_addr  = 32'd0;
    busB.BUS_wdata = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("initBusy", 32'(busA.BUS_busy), 32'd0);
    checkOutput("initRdata", busA.BUS_rdata, 32'd0);
    checkOutput("initValid", 32'(busA.BUS_rdata_valid), 32'd0);
    checkOutput("initDone", 32'(busA.BUS_write_done), 32'd0);
    checkOutput("initErr", 32'(busA.BUS_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'(i * 4), $urandom, -1);
    end

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, -1);
    applyStimulus(1'b0, 32'h10, 32'd0, -1);
    applyStimulus(1'b1, 32'h13, 32'h11111111, -1);
    applyStimulus(1'b1, 32'h400, 32'h22222222, -1);
    applyStimulus(1'b0, 32'h10, 32'd0, -1);
    applyStimulus(1'b0, 32'h401, 32'd0, -1);
    applyStimulus(1'b1, 32'h40, 32'hA5A5F00D, 1);
    applyStimulus(1'b0, 32'h40, 32'd0, 0);
    applyStimulus(1'b1, 32'h44, 32'h0BADCAFE, WAIT0 + 1);
    applyStimulus(1'b0, 32'h44, 32'd0, WAIT0 + 1);

    applyResetMid(32'h20, 32'h5EC0FFEE);
    applyStimulus(1'b0, 32'h20, 32'd0, -1);

    runFastPair(32'h3FC, 32'hCAFEF00D);
    runFastPair(32'h3FC, 32'h12345678);

    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7) begin
        addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      end else if (sel == 7) begin
        addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      end else begin
        addr = $urandom;
        if (addr < 32'(4 * DEPTH)) addr = addr | 32'h0001_0000;
      end
      dup = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WAIT0 + 1)) : -1;
      applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, dup);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'(i * 4), 32'd0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
